syscall_console: RTL and testbench
==================================

# syscall_console

Console/exit back-end that sits directly downstream of the syscall execution stage. It accepts decoded syscall requests (code plus value) through a valid/ready handshake, buffers display values in a small FIFO, and streams them to the console sink through a second valid/ready port. An exit request stops intake, drains every queued display value, then raises a sticky `halt` for the testbench or top level to end simulation.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `DISPLAY_CODE`, 32'd1: code value meaning display.
- `EXIT_CODE`, 32'd2: code value meaning exit.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sys_valid`  in  1  syscall request present.
- `sys_ready`  out  1  block can accept a request this cycle.
- `sys_code`  in  32  request type (display, exit, anything else = nop).
- `sys_value`  in  32  value to display.
- `out_valid`  out  1  console word available.
- `out_ready`  in  1  console sink accepts the word.
- `out_data`  out  32  console word (FIFO head).
- `halt`  out  1  sticky: exit completed, FIFO drained.
- `busy`  out  1  FIFO non-empty or in DRAIN.
- `disp_count`  out  32  number of display words delivered to the sink.

## Operation
- States: RUN, DRAIN, HALTED.
- RUN: `sys_ready` = !full. A request is accepted when `sys_valid && sys_ready`.
  - Display code: push `sys_value`.
  - Exit code: push nothing; next state DRAIN.
  - Any other code: accepted and discarded (nop). No state change.
- DRAIN: `sys_ready` = 0. Pops continue. When the FIFO is empty, the next state is HALTED.
- HALTED: `sys_ready` = 0, `out_valid` = 0, `halt` = 1. Leaves HALTED only on `rst`.
- Pop: `out_valid` = !empty, and `out_data` = head entry. A pop happens on `out_valid && out_ready`, and `disp_count` increments on the same edge; it wraps modulo 2^32.
- Push and pop in the same cycle: count unchanged, and both pointers advance. Allowed when full (the pop side still drains, but `sys_ready` is already 0, so no push) and when empty (no bypass: the pushed word appears next cycle).
- Pointers: log2(DEPTH) bits, wrap naturally. Occupancy counter: $clog2(DEPTH+1) bits.
- `sys_ready` depends only on registered state and never combinationally on `sys_valid` or `out_ready`.

## Timing
- Reset values: state = RUN, pointers = 0, count = 0, `sys_ready` = 1, `out_valid` = 0, `out_data` = 0, `halt` = 0, `busy` = 0, `disp_count` = 0.
- Reset asserted mid-operation: everything returns to the reset values immediately (asynchronous), and queued words are lost.
- Accept-to-`out_valid` latency: 1 cycle when the FIFO is empty.
- Exit accepted at edge N with the FIFO empty: state is DRAIN after N. `halt` = 1 after edge N+1.
- Exit accepted with k words queued and `out_ready` held at 1: `halt` rises one edge after the k-th pop.
- `out_data` is stable while `out_valid && !out_ready`.

## Configuration
- `SYSCON_TRACE_EN` defined:
  - Each pop prints `out_data` in decimal via `$display`.
  - Entry to HALTED prints "EXIT" with `disp_count`.
  - All of this is simulation-only code inside the macro guard.
- Undefined: no system tasks are compiled. Port behaviour is identical in both builds.

## Structure
- Shared package `bubble_sys_pkg`:
  - syscall code constants (NOP = 0, DISPLAY = 1, EXIT = 2), which are also the parameter defaults.
  - state enum `syscon_state_t` {RUN, DRAIN, HALTED}.
  - syscall instruction ID constant (26), for use by the upstream stage.
- Sub-module `sys_fifo`: parameterised synchronous FIFO (DEPTH, WIDTH = 32) with push, pop, full, empty, head, and asynchronous active-high reset. The top holds the FSM, handshake gating and counter.

## Test plan
- Reset, then push display 5, 7, 9 with `out_ready` = 1 → `out_data` sequence 5, 7, 9, each 1 cycle after accept; `disp_count` = 3.
- `out_ready` = 0, push 8 displays → `sys_ready` falls after the 8th. A 9th request is held until `out_ready` = 1; the 9th word is delivered after the first 8 in order.
- Queue 4 displays with `out_ready` = 0, send exit → `sys_ready` = 0. Raise `out_ready`: 4 words out, `halt` = 1 one edge after the last pop, and it stays 1.
- Requests with codes 0 and 3 → accepted, no output, `disp_count` unchanged, state stays RUN.
- Empty FIFO, exit → `halt` = 1 exactly two edges after accept. Further `sys_valid` is ignored.
- Assert `rst` asynchronously mid-drain with 3 words queued → `out_valid` = 0, `halt` = 0, `disp_count` = 0 immediately. After release the block accepts new requests.

Source files
------------

// File: rtl/bubble_sys_pkg.sv
// Shared syscall definitions: code values, console FSM states and the syscall instruction ID.
package bubble_sys_pkg;

    localparam logic [31:0] SYS_NOP     = 32'd0;
    localparam logic [31:0] SYS_DISPLAY = 32'd1;
    localparam logic [31:0] SYS_EXIT    = 32'd2;

    // Opcode the upstream decode stage uses to recognise a syscall instruction.
    localparam int SYSCALL_INSN_ID = 26;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } syscon_state_t;

endpackage

// File: rtl/syscall_console_sys_fifo.sv
// sys_fifo: synchronous FIFO with occupancy counter, head-of-queue output and async active-high reset.
module sys_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/syscall_console.sv
// syscall_console: buffers display syscalls for the console sink and halts after an exit drains the queue.
// Optional simulation trace of delivered words and the exit event is enabled with SYSCON_TRACE_EN.
module syscall_console
    import bubble_sys_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] DISPLAY_CODE = SYS_DISPLAY,
    parameter logic [31:0] EXIT_CODE    = SYS_EXIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sys_valid,
    output logic        sys_ready,
    input  logic [31:0] sys_code,
    input  logic [31:0] sys_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        halt,
    output logic        busy,
    output logic [31:0] disp_count
);

    syscon_state_t state;
    logic          full;
    logic          empty;
    logic [31:0]   head;
    logic          accept;
    logic          push;
    logic          pop;

    // Handshake gating uses only registered state, never the partner's valid/ready.
    assign sys_ready = (state == RUN) && !full;
    assign out_valid = !empty && (state != HALTED);
    assign out_data  = head;
    assign halt      = (state == HALTED);
    assign busy      = !empty || (state == DRAIN);

    assign accept = sys_valid && sys_ready;
    assign push   = accept && (sys_code == DISPLAY_CODE);
    assign pop    = out_valid && out_ready;

    sys_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (sys_value),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            disp_count <= '0;
        end else begin
            if (pop) begin
                disp_count <= disp_count + 32'd1;
            end
            unique case (state)
                RUN: begin
                    if (accept && (sys_code == EXIT_CODE)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state <= HALTED;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

`ifdef SYSCON_TRACE_EN
    always @(posedge clk) begin
        if (!rst && pop) begin
            $display("%0d", out_data);
        end
        if (!rst && (state == DRAIN) && empty) begin
            $display("EXIT %0d", disp_count);
        end
    end
`else
`endif

endmodule

// File: tb/tb_syscall_console.sv
// Self-checking bench for syscall_console: directed and randomized traffic against a queue-based reference model.
module tb_syscall_console;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sys_valid;
    logic        sys_ready;
    logic [31:0] sys_code;
    logic [31:0] sys_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        halt;
    logic        busy;
    logic [31:0] disp_count;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [31:0] model_q[$];
    bit          model_drain;
    bit          model_halt;
    logic [31:0] model_count;
    bit          last_accept;

    syscall_console #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sys_valid  (sys_valid),
        .sys_ready  (sys_ready),
        .sys_code   (sys_code),
        .sys_value  (sys_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .halt       (halt),
        .busy       (busy),
        .disp_count (disp_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        model_q.delete();
        model_drain = 1'b0;
        model_halt  = 1'b0;
        model_count = 32'd0;
        last_accept = 1'b0;
    endfunction

    // Compare every observable output with what the model predicts for the current cycle.
    task automatic checkOutput();
        bit exp_ready;
        bit exp_valid;
        exp_ready = !model_halt && !model_drain && (model_q.size() < DEPTH);
        exp_valid = !model_halt && (model_q.size() > 0);
        check("sys_ready", 32'(sys_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) check("out_data", out_data, model_q[0]);
        check("halt", 32'(halt), 32'(model_halt));
        check("busy", 32'(busy), 32'((model_q.size() > 0) || model_drain));
        check("disp_count", disp_count, model_count);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic applyStimulus(input bit v, input logic [31:0] code, input logic [31:0] value,
                                 input bit ordy);
        bit exp_ready;
        bit exp_valid;
        bit drain_pre;
        int size_pre;
        @(negedge clk);
        sys_valid = v;
        sys_code  = code;
        sys_value = value;
        out_ready = ordy;
        #1;
        checkOutput();
        exp_ready = !model_halt && !model_drain && (model_q.size() < DEPTH);
        exp_valid = !model_halt && (model_q.size() > 0);
        drain_pre = model_drain;
        size_pre  = model_q.size();
        @(posedge clk);
        last_accept = v && exp_ready;
        if (exp_valid && ordy) begin
            void'(model_q.pop_front());
            model_count = model_count + 32'd1;
        end
        if (last_accept) begin
            if (code == 32'd1) model_q.push_back(value);
            else if (code == 32'd2) model_drain = 1'b1;
        end
        if (drain_pre && size_pre == 0) begin
            model_drain = 1'b0;
            model_halt  = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        sys_valid = 1'b0;
        sys_code  = 32'd0;
        sys_value = 32'd0;
        out_ready = 1'b0;
        #1;
        modelReset();
        checkOutput();
        check("reset_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drainAll(input string tag);
        int budget;
        budget = 0;
        while (model_q.size() > 0 && budget < 40) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
            budget++;
        end
        if (budget >= 40) check({tag, "_timeout"}, 32'd1, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        int budget;
        int r;
        logic [31:0] code;
        rst       = 1'b1;
        sys_valid = 1'b0;
        sys_code  = 32'd0;
        sys_value = 32'd0;
        out_ready = 1'b0;
        modelReset();
        doReset();

        // Three displays with the sink always ready.
        applyStimulus(1'b1, 32'd1, 32'd5, 1'b1);
        applyStimulus(1'b1, 32'd1, 32'd7, 1'b1);
        applyStimulus(1'b1, 32'd1, 32'd9, 1'b1);
        drainAll("three");
        check("three_count", disp_count, 32'd3);

        // Fill the FIFO with the sink stalled, then hold a ninth request.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'd1, 32'(100 + i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1, 32'd900, 1'b0);
        budget = 0;
        do begin
            applyStimulus(1'b1, 32'd1, 32'd900, 1'b1);
            budget++;
        end while (!last_accept && budget < 20);
        if (!last_accept) check("ninth_timeout", 32'd1, 32'd0);
        drainAll("full");

        // Codes other than display and exit are consumed silently.
        applyStimulus(1'b1, 32'd0, 32'd55, 1'b1);
        applyStimulus(1'b1, 32'd3, 32'd66, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);

        // Random mix of displays and nops with a random sink.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            code = (r < 8) ? 32'd1 : ((r == 8) ? 32'd0 : 32'd3);
            applyStimulus(1'($urandom_range(0, 1)), code, $urandom, 1'($urandom_range(0, 2) != 0));
        end
        drainAll("random");

        // Exit with four words queued and the sink stalled.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd1, 32'(40 + i), 1'b0);
        applyStimulus(1'b1, 32'd2, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1, 32'd77, 1'b0);
        budget = 0;
        while (!model_halt && budget < 30) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
            budget++;
        end
        if (!model_halt) check("exit4_timeout", 32'd1, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1, 32'd88, 1'b1);

        // Exit on an empty FIFO halts two edges after acceptance.
        doReset();
        applyStimulus(1'b1, 32'd2, 32'd0, 1'b1);
        applyStimulus(1'b1, 32'd1, 32'd11, 1'b1);
        applyStimulus(1'b1, 32'd1, 32'd12, 1'b1);
        applyStimulus(1'b1, 32'd1, 32'd13, 1'b1);
        check("empty_exit_halt", 32'(halt), 32'd1);

        // Asynchronous reset in the middle of a drain with three words queued.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1, 32'(i + 1), 1'b1);
        drainAll("pre");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1, 32'(20 + i), 1'b0);
        applyStimulus(1'b1, 32'd2, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        sys_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_halt", 32'(halt), 32'd0);
        check("async_disp_count", disp_count, 32'd0);
        check("async_sys_ready", 32'(sys_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'd1, 32'd321, 1'b1);
        drainAll("post");
        check("post_count", disp_count, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
